prime_sieve_engine: RTL

PRIME_SIEVE_ENGINE -- requirements
Module: prime_sieve_engine

---
 rtl/prime_sieve_engine.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/prime_sieve_engine.sv
// Sieve of Eratosthenes over a 1-bit table: clear 0..limit, strike composites,
// then stream surviving indices >= 2 over a valid/ready handshake.
module prime_sieve_engine #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] limit,
  output logic              busy,
  output logic              done,
  output logic              prime_valid,
  input  logic              prime_ready,
  output logic [ADDR_W-1:0] prime_data,
  output logic [CNT_W-1:0]  prime_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, MARK, EMIT, DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   lim, lim_n, p, p_n, m, m_n;
  logic [ADDR_W:0]     i, i_n;
  logic                ph, ph_n;
  logic [CNT_W-1:0]    cnt, cnt_n;

  logic                tbl [DEPTH];
  logic                we, wd, re, rd_q;
  logic [ADDR_W-1:0]   wa, ra;

  logic [2*ADDR_W-1:0] pp;
  logic [ADDR_W:0]     mp;

  // Full-width square and one-bit-wider stride sum so neither test can wrap.
  assign pp = {{ADDR_W{1'b0}}, p} * {{ADDR_W{1'b0}}, p};
  assign mp = {1'b0, m} + {1'b0, p};

  // ph marks the cycle after a read was issued, when rd_q is valid.
  assign prime_valid = (state == EMIT) && ph && rd_q;
  assign prime_data  = i[ADDR_W-1:0];
  assign prime_count = cnt;
  assign busy        = (state == CLEAR) || (state == SCAN) || (state == MARK) || (state == EMIT);
  assign done        = (state == DONE);

  always_comb begin
    state_n = state;
    lim_n   = lim;
    p_n     = p;
    m_n     = m;
    i_n     = i;
    ph_n    = ph;
    cnt_n   = cnt;
    we      = 1'b0;
    wd      = 1'b0;
    wa      = i[ADDR_W-1:0];
    re      = 1'b0;
    ra      = i[ADDR_W-1:0];
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = CLEAR;
          lim_n   = limit;
          cnt_n   = '0;
          i_n     = '0;
          p_n     = '0;
          m_n     = '0;
          ph_n    = 1'b0;
        end
      end
      CLEAR: begin
        we = 1'b1;
        wd = 1'b1;
        if (i[ADDR_W-1:0] == lim) begin
          state_n = SCAN;
          p_n     = ADDR_W'(2);
          ph_n    = 1'b0;
        end else begin
          i_n = i + (ADDR_W+1)'(1);
        end
      end
      SCAN: begin
        if (pp > {{ADDR_W{1'b0}}, lim}) begin
          state_n = EMIT;
          i_n     = (ADDR_W+1)'(2);
          ph_n    = 1'b0;
        end else if (!ph) begin
          re   = 1'b1;
          ra   = p;
          ph_n = 1'b1;
        end else if (rd_q) begin
          state_n = MARK;
          m_n     = pp[ADDR_W-1:0];
          ph_n    = 1'b0;
        end else begin
          p_n  = p + ADDR_W'(1);
          ph_n = 1'b0;
        end
      end
      MARK: begin
        we = 1'b1;
        wd = 1'b0;
        wa = m;
        if (mp > {1'b0, lim}) begin
          state_n = SCAN;
          p_n     = p + ADDR_W'(1);
        end else begin
          m_n = mp[ADDR_W-1:0];
        end
      end
      EMIT: begin
        if (!ph) begin
          if (i > {1'b0, lim}) begin
            state_n = DONE;
          end else begin
            re   = 1'b1;
            ph_n = 1'b1;
          end
        end else if (!rd_q) begin
          i_n  = i + (ADDR_W+1)'(1);
          ph_n = 1'b0;
        end else if (prime_ready) begin
          i_n  = i + (ADDR_W+1)'(1);
          ph_n = 1'b0;
          if (cnt != '1) cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lim   <= '0;
      p     <= '0;
      m     <= '0;
      i     <= '0;
      ph    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      lim   <= lim_n;
      p     <= p_n;
      m     <= m_n;
      i     <= i_n;
      ph    <= ph_n;
      cnt   <= cnt_n;
    end
  end

  // Table and its read register are deliberately not reset; CLEAR re-initialises.
  always_ff @(posedge clk) begin
    if (we) tbl[wa] <= wd;
    if (re) rd_q <= tbl[ra];
  end

endmodule
